// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between NUM_REQ requesters.
// Requests are granted one at a time, the operands are registered onto the
// alu_* outputs for one execute cycle, and the registered result is returned
// with the requester index over a valid/ready response channel.
// Build option: define ALU_ARB_FIXED_PRI_EN for fixed (lowest-index-wins)
// priority; by default arbitration is round-robin.

package definitions;
  typedef enum logic [3:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    AND  = 4'd2,
    OR   = 4'd3,
    XOR  = 4'd4,
    NOR  = 4'd5,
    SLT  = 4'd6,
    SLTU = 4'd7
  } op_code;
endpackage

module alu_arbiter
  import definitions::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ-1:0][31:0] req_rs_i,
  input  logic [NUM_REQ-1:0][31:0] req_rt_i,
  input  op_code [NUM_REQ-1:0]     req_op_i,
  output logic [31:0]              alu_rs_o,
  output logic [31:0]              alu_rt_o,
  output op_code                   alu_op_o,
  input  logic [31:0]              alu_result_i,
  input  logic                     alu_zero_i,
  output logic                     resp_valid_o,
  input  logic                     resp_ready_i,
  output logic [IDW-1:0]           resp_id_o,
  output logic [31:0]              resp_result_o,
  output logic                     resp_zero_o
);

  // state | meaning
  // IDLE  | offering a grant to the next valid requester
  // EXEC  | latched operands drive the ALU for one cycle
  // RESP  | result held on the response channel until accepted
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] winner;
  logic [IDW-1:0] cand;
  logic [IDW:0]   sum;
  logic           found;
  logic           grant;

  // Search for the first valid requester starting at ptr, wrapping at NUM_REQ.
  // In the fixed-priority build ptr is held at zero, so this degenerates to a
  // lowest-index-first search.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    sum    = '0;
    cand   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NUM_REQ)) begin
        sum = sum - (IDW+1)'(NUM_REQ);
      end
      cand = sum[IDW-1:0];
      if (!found && req_valid_i[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_nxt    = state;
    req_ready_o  = '0;
    resp_valid_o = 1'b0;
    grant        = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          req_ready_o[winner] = 1'b1;
          grant               = 1'b1;
          state_nxt           = EXEC;
        end
      end
      EXEC: begin
        state_nxt = RESP;
      end
      RESP: begin
        resp_valid_o = 1'b1;
        if (resp_ready_i) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

`ifndef ALU_ARB_FIXED_PRI_EN
  logic [IDW-1:0] winner_inc;

  // Pointer successor, wrapping at NUM_REQ (which need not be a power of two).
  always_comb begin
    if (winner == IDW'(NUM_REQ - 1)) begin
      winner_inc = '0;
    end else begin
      winner_inc = winner + IDW'(1);
    end
  end
`endif

  // Operand latch on grant, result capture at the end of EXEC. The alu_*
  // registers deliberately keep their last value outside EXEC.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr           <= '0;
      alu_rs_o      <= '0;
      alu_rt_o      <= '0;
      alu_op_o      <= ADD;
      resp_id_o     <= '0;
      resp_result_o <= '0;
      resp_zero_o   <= 1'b0;
    end else begin
      if (grant) begin
        alu_rs_o  <= req_rs_i[winner];
        alu_rt_o  <= req_rt_i[winner];
        alu_op_o  <= req_op_i[winner];
        resp_id_o <= winner;
`ifdef ALU_ARB_FIXED_PRI_EN
        ptr       <= '0;
`else
        ptr       <= winner_inc;
`endif
      end
      if (state == EXEC) begin
        resp_result_o <= alu_result_i;
        resp_zero_o   <= alu_zero_i;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed operations, round-robin
// order, response back-pressure, reset abort and a randomized phase, all
// checked against a behavioural model of arbitration and ALU arithmetic.
module tb_alu_arbiter;
  import definitions::*;

  localparam int N = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic [N-1:0]       req_valid;
  logic [N-1:0]       req_ready;
  logic [N-1:0][31:0] req_rs;
  logic [N-1:0][31:0] req_rt;
  op_code [N-1:0]     req_op;
  logic [31:0]        alu_rs;
  logic [31:0]        alu_rt;
  op_code             alu_op;
  logic [31:0]        alu_result;
  logic               alu_zero;
  logic               resp_valid;
  logic               resp_ready;
  logic [1:0]         resp_id;
  logic [31:0]        resp_result;
  logic               resp_zero;

  int n_cmp     = 0;
  int n_err     = 0;
  int model_ptr = 0;

  alu_arbiter #(.NUM_REQ(N)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_rs_i      (req_rs),
    .req_rt_i      (req_rt),
    .req_op_i      (req_op),
    .alu_rs_o      (alu_rs),
    .alu_rt_o      (alu_rt),
    .alu_op_o      (alu_op),
    .alu_result_i  (alu_result),
    .alu_zero_i    (alu_zero),
    .resp_valid_o  (resp_valid),
    .resp_ready_i  (resp_ready),
    .resp_id_o     (resp_id),
    .resp_result_o (resp_result),
    .resp_zero_o   (resp_zero)
  );

  always #5 clk = ~clk;

  // Arithmetic of each operation, straight from its definition.
  function automatic logic [31:0] alu_ref(op_code op, logic [31:0] a, logic [31:0] b);
    case (op)
      ADD:     return a + b;
      SUB:     return a - b;
      AND:     return a & b;
      OR:      return a | b;
      XOR:     return a ^ b;
      NOR:     return ~(a | b);
      SLT:     return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      SLTU:    return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Environment ALU feeding the arbiter.
  always_comb begin
    alu_result = alu_ref(alu_op, alu_rs, alu_rt);
    alu_zero   = (alu_result == 32'd0);
  end

  // Expected winner: first valid index scanning upward from the model pointer.
  function automatic int pick(logic [N-1:0] v);
    int base;
`ifdef ALU_ARB_FIXED_PRI_EN
    base = 0;
`else
    base = model_ptr;
`endif
    for (int k = 0; k < N; k++) begin
      if (v[2'((base + k) % N)]) return (base + k) % N;
    end
    return -1;
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_point();
    @(posedge clk);
    #1;
  endtask

  function automatic op_code rand_op();
    return op_code'(4'($urandom_range(0, 7)));
  endfunction

  task automatic set_req(int i, logic [31:0] a, logic [31:0] b, op_code op);
    logic [1:0] j;
    j = 2'(i);
    req_valid[j] = 1'b1;
    req_rs[j]    = a;
    req_rt[j]    = b;
    req_op[j]    = op;
  endtask

  task automatic set_rand_req(int i);
    logic [31:0] a;
    a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
    set_req(i, a, ($urandom_range(0, 3) == 0) ? a : $urandom, rand_op());
  endtask

  // One full transaction from the current drive point: wait for the grant,
  // check it against the model, check EXEC, hold RESP for 'stall' extra
  // cycles, then hand-shake. Returns at the drive point after the handshake.
  task automatic run_one(int stall, bit reload, bit imm);
    bit          found;
    int          ew;
    logic [1:0]  j;
    logic [31:0] ers, ert, eres;
    op_code      eop;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (c == 0) check("idle_resp_valid", 64'(resp_valid), 64'(0));
      check("ready_onehot", 64'($countones(req_ready) <= 1), 64'(1));
      if (|req_ready) begin
        found = 1'b1;
        if (imm) check("grant_resume", 64'(c), 64'(0));
      end else begin
        drive_point();
      end
    end
    if (!found) begin
      check("grant_timeout", 64'(0), 64'(1));
      return;
    end
    ew = pick(req_valid);
    j  = 2'(ew);
    check("grant", 64'(req_ready), 64'(1) << ew);
    ers  = req_rs[j];
    ert  = req_rt[j];
    eop  = req_op[j];
    eres = alu_ref(eop, ers, ert);
`ifdef ALU_ARB_FIXED_PRI_EN
    model_ptr = 0;
`else
    model_ptr = (ew + 1) % N;
`endif
    drive_point();
    if (reload) set_rand_req(ew);
    else req_valid[j] = 1'b0;
    resp_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("exec_valid", 64'(resp_valid), 64'(0));
    check("exec_ready", 64'(req_ready), 64'(0));
    check("exec_alu_rs", 64'(alu_rs), 64'(ers));
    check("exec_alu_rt", 64'(alu_rt), 64'(ert));
    check("exec_alu_op", 64'(alu_op), 64'(eop));
    for (int c = 0; c <= stall; c++) begin
      drive_point();
      resp_ready = (c == stall);
      @(negedge clk);
      check("resp_valid", 64'(resp_valid), 64'(1));
      check("resp_id", 64'(resp_id), 64'(ew));
      check("resp_result", 64'(resp_result), 64'(eres));
      check("resp_zero", 64'(resp_zero), 64'(eres == 32'd0));
      check("resp_ready_blocked", 64'(req_ready), 64'(0));
    end
    drive_point();
    resp_ready = 1'b0;
  endtask

  task automatic check_reset_values(string pfx);
    check({pfx, "_req_ready"}, 64'(req_ready), 64'(0));
    check({pfx, "_resp_valid"}, 64'(resp_valid), 64'(0));
    check({pfx, "_resp_id"}, 64'(resp_id), 64'(0));
    check({pfx, "_resp_result"}, 64'(resp_result), 64'(0));
    check({pfx, "_resp_zero"}, 64'(resp_zero), 64'(0));
    check({pfx, "_alu_rs"}, 64'(alu_rs), 64'(0));
    check({pfx, "_alu_rt"}, 64'(alu_rt), 64'(0));
    check({pfx, "_alu_op"}, 64'(alu_op), 64'(ADD));
  endtask

  initial begin
    logic [1:0] j;
    reset      = 1'b1;
    req_valid  = '0;
    req_rs     = '0;
    req_rt     = '0;
    resp_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = 2'(i);
      req_op[j] = ADD;
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_reset_values("reset");
    drive_point();

    // Directed single-requester operations.
    set_req(0, 32'd8, 32'd4, ADD);
    run_one(0, 1'b0, 1'b0);
    set_req(1, 32'd10, 32'd10, SUB);
    run_one(0, 1'b0, 1'b0);
    set_req(2, 32'd4, 32'd8, SUB);
    run_one(0, 1'b0, 1'b0);
    set_req(3, 32'hFFFF_0000, 32'h0000_FFFF, OR);
    run_one(0, 1'b0, 1'b0);
    set_req(3, 32'hFFFF_0000, 32'h0000_FFFF, AND);
    run_one(1, 1'b0, 1'b0);

    // All requesters held valid: rotation order, then back-pressure.
    for (int i = 0; i < N; i++) set_rand_req(i);
    run_one(0, 1'b1, 1'b0);
    repeat (4) run_one(0, 1'b1, 1'b1);
    run_one(5, 1'b1, 1'b1);
    run_one(0, 1'b1, 1'b1);

    // Randomized traffic with requesters coming and going before grant.
    repeat (40) begin
      for (int i = 0; i < N; i++) begin
        j = 2'(i);
        if (!req_valid[j] && $urandom_range(0, 1) == 1) set_rand_req(i);
        else if (req_valid[j] && $urandom_range(0, 7) == 0) req_valid[j] = 1'b0;
      end
      if (req_valid == '0) set_rand_req(int'($urandom_range(0, N - 1)));
      run_one(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1'b1);
    end

    // Reset during EXEC aborts the operation.
    req_valid = '0;
    set_req(2, 32'h1234_5678, 32'h0000_0001, ADD);
    @(negedge clk);
    check("abort_grant", 64'(req_ready), 64'(4'b0100));
    drive_point();
    reset     = 1'b1;
    req_valid = '0;
    drive_point();
    reset     = 1'b0;
    model_ptr = 0;
    @(negedge clk);
    check_reset_values("abort");
    repeat (4) begin
      drive_point();
      @(negedge clk);
      check("abort_no_resp", 64'(resp_valid), 64'(0));
    end
    drive_point();

    // Pointer restarts at zero after reset.
    set_rand_req(3);
    set_rand_req(0);
    run_one(0, 1'b0, 1'b0);
    run_one(2, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares one `alu` instance between NUM_REQ requesters (e.g. decode, address-gen, branch-compare).
- Each requester offers an operand pair and an `op_code` (from the `definitions` package) over a valid/ready handshake.
- The arbiter grants one requester, drives the shared ALU inputs, and registers `result_o`/`zero`.
- It returns the result with the requester ID over a valid/ready response channel.
- It sits between the requesters and the combinational `alu`, which it instantiates externally through its `alu_*` ports.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IDW, $clog2(NUM_REQ), width of requester ID.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid_i  input  NUM_REQ  per-requester request valid.
- req_ready_o  output  NUM_REQ  per-requester grant (one-hot or zero).
- req_rs_i  input  NUM_REQ x 32  per-requester rs operand.
- req_rt_i  input  NUM_REQ x 32  per-requester rt operand.
- req_op_i  input  NUM_REQ x op_code  per-requester operation.
- alu_rs_o  output  32  to `alu.rs_i`.
- alu_rt_o  output  32  to `alu.rt_i`.
- alu_op_o  output  op_code  to `alu.op_i`.
- alu_result_i  input  32  from `alu.result_o`.
- alu_zero_i  input  1  from `alu.zero`.
- resp_valid_o  output  1  response valid.
- resp_ready_i  input  1  response consumer ready.
- resp_id_o  output  IDW  index of the granted requester.
- resp_result_o  output  32  registered ALU result.
- resp_zero_o  output  1  registered zero flag.

Behaviour:
- Reset values:
  - state=IDLE, ptr=0.
  - req_ready_o=0, resp_valid_o=0, resp_id_o=0, resp_result_o=0, resp_zero_o=0.
  - alu_rs_o=0, alu_rt_o=0, alu_op_o=ADD.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Winner = first asserted req_valid_i searching from index ptr upward, wrapping modulo NUM_REQ.
  - req_ready_o[winner]=1, combinational, in IDLE only; all other bits are 0.
  - On valid&ready: latch rs/rt/op into the alu_* registers and the winner into resp_id_o, set ptr=(winner+1) mod NUM_REQ, go to EXEC.
  - No valid request: stay in IDLE, all ready bits 0.
- EXEC (one cycle):
  - alu_* outputs are stable from the latched operands.
  - At cycle end, capture alu_result_i into resp_result_o and alu_zero_i into resp_zero_o; go to RESP.
- RESP:
  - resp_valid_o=1.
  - resp_id_o, resp_result_o and resp_zero_o are held constant until resp_ready_i=1.
  - On handshake: resp_valid_o=0 next cycle, go to IDLE.
  - No grants are issued while in EXEC or RESP.
- Latency and throughput:
  - Grant in cycle T → resp_valid_o high in cycle T+2.
  - Peak throughput is one operation per 3 cycles.
- alu_* outputs hold their last value outside EXEC; they are not cleared.
- Requester rules:
  - A requester must hold valid and operands stable until granted.
  - Deasserting valid before grant is legal and has no side effect.
- Arithmetic and width are owned by `alu`; the arbiter passes 32-bit values unmodified.
- Reset during EXEC or RESP aborts the operation. No response is produced and all outputs return to reset values on the next edge.
- resp_ready_i high while resp_valid_o=0 is ignored.

Optional Feature:
- Macro: ALU_ARB_FIXED_PRI_EN.
- When defined: fixed priority. The lowest-index valid requester always wins; ptr is not used and stays 0.
- When undefined: round-robin as described above.
- All other timing and handshake behaviour is identical in both builds.

Test Plan:
- Req0 only: rs=8, rt=4, ADD, resp_ready_i=1 → resp at grant+2: id=0, result=12, zero=0; one-cycle resp_valid_o.
- Req1: rs=10, rt=10, SUB → result=0, zero=1. Req2: rs=4, rt=8, SUB → result=32'hFFFF_FFFC, zero=0.
- Req3: rs=32'hFFFF_0000, rt=32'h0000_FFFF, OR → 32'hFFFF_FFFF. Same operands with AND → 32'h0000_0000, zero=1.
- All four requesters held valid, round-robin build → resp_id_o sequence 0,1,2,3,0; req_ready_o never more than one-hot.
- resp_ready_i low for 5 cycles during RESP → resp_valid_o and payload held stable, req_ready_o=0 throughout; grant resumes the cycle after the handshake.
- Reset asserted during EXEC → no response; all outputs at reset values. With ALU_ARB_FIXED_PRI_EN and all requesters valid → resp_id_o always 0.
